// File: rtl/ctrl_pkg.sv
// Shared encodings, ALU/forward codes and the per-stage control bundle
// for the pipelined MIPS control path.
package ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             branch_ne;
        logic [3:0]       alu_control;
        logic             alu_source;
        logic             alu_source_shift;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dst;
    } ctrl_t;

    // r0 is hard-wired, so a producer targeting it never creates a dependency.
    function automatic logic src_match(input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/control_pipe_if.sv
// ID-stage inputs and per-stage control outputs of control_pipe.
interface control_pipe_if #(parameter int ADDR_W = 5);
    logic [31:0]       instr_id;
    logic              instr_valid;
    logic              stall_ext;
    logic              flush_id;
    logic              illegal_id;
    logic              hazard_stall;
    logic [3:0]        ex_alu_control;
    logic              ex_alu_source;
    logic              ex_alu_source_shift;
    logic              ex_branch;
    logic              ex_branch_ne;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [ADDR_W-1:0] wb_dst;

    modport master (
        output instr_id, instr_valid, stall_ext, flush_id,
        input  illegal_id, hazard_stall, ex_alu_control, ex_alu_source,
               ex_alu_source_shift, ex_branch, ex_branch_ne, fwd_a, fwd_b,
               mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_dst
    );

    modport slave (
        input  instr_id, instr_valid, stall_ext, flush_id,
        output illegal_id, hazard_stall, ex_alu_control, ex_alu_source,
               ex_alu_source_shift, ex_branch, ex_branch_ne, fwd_a, fwd_b,
               mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_dst
    );
endinterface

// File: rtl/control_decode.sv
// Combinational ID-stage decoder: instruction word to control bundle.
// Source fields an instruction does not read are forced to r0 so they never match.
module control_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             unused_fields;

    assign opcode        = instr[31:26];
    assign rs            = instr[25:21];
    assign rt            = instr[20:16];
    assign rd            = instr[15:11];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[10:6];

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.dst       = rd;
                ctrl.rs        = rs;
                ctrl.rt        = rt;
                case (funct)
                    FN_ADD:  ctrl.alu_control = ALU_ADD;
                    FN_SUB:  ctrl.alu_control = ALU_SUB;
                    FN_AND:  ctrl.alu_control = ALU_AND;
                    FN_OR:   ctrl.alu_control = ALU_OR;
                    FN_XOR:  ctrl.alu_control = ALU_XOR;
                    FN_NOR:  ctrl.alu_control = ALU_NOR;
                    FN_SLT:  ctrl.alu_control = ALU_SLT;
                    FN_SLLV: ctrl.alu_control = ALU_SLL;
                    FN_SRLV: ctrl.alu_control = ALU_SRL;
                    FN_SRAV: ctrl.alu_control = ALU_SRA;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Immediate shifts take shamt in place of rs.
                        ctrl.alu_source_shift = 1'b1;
                        ctrl.rs               = '0;
                        ctrl.alu_control      = (funct == FN_SLL) ? ALU_SLL :
                                                (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_source  = 1'b1;
                ctrl.rs          = rs;
                ctrl.dst         = rt;
                ctrl.alu_control = (opcode == OP_ADDI) ? ALU_ADD :
                                   (opcode == OP_ANDI) ? ALU_AND :
                                   (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.alu_source  = 1'b1;
                ctrl.alu_control = ALU_ADD;
                ctrl.rs          = rs;
                ctrl.dst         = rt;
            end
            OP_SW: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_source  = 1'b1;
                ctrl.alu_control = ALU_ADD;
                ctrl.rs          = rs;
                ctrl.rt          = rt;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch      = 1'b1;
                ctrl.branch_ne   = (opcode == OP_BNE);
                ctrl.alu_control = ALU_SUB;
                ctrl.rs          = rs;
                ctrl.rt          = rt;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use / RAW hazard stall and EX operand forwarding selects.
module control_pipe
    import ctrl_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter bit FWD_EN = 1'b1
)(
    input  logic           clk,
    input  logic           reset,
    control_pipe_if.slave  bus
);

    ctrl_t id_ctrl;
    ctrl_t id_ex_reg;
    ctrl_t ex_mem_reg;
    ctrl_t mem_wb_reg;
    ctrl_t id_ex_next;
    logic  id_illegal;
    logic  hazard;

    logic [1:0][REG_W-1:0] id_src;
    logic [1:0][REG_W-1:0] ex_src;
    logic [1:0]            load_hit;
    logic [1:0]            raw_hit;
    logic [1:0][1:0]       fwd_sel;

    control_decode u_decode (
        .instr   (bus.instr_id),
        .ctrl    (id_ctrl),
        .illegal (id_illegal)
    );

    // Index 0 is rs (operand A), index 1 is rt (operand B).
    assign id_src = {id_ctrl.rt, id_ctrl.rs};
    assign ex_src = {id_ex_reg.rt, id_ex_reg.rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign load_hit[gi] = id_ex_reg.mem_read &&
                                  src_match(id_ex_reg.dst, id_src[gi]);
            // Without forwarding, any in-flight writer in EX or MEM must drain first.
            assign raw_hit[gi]  = !FWD_EN &&
                                  ((id_ex_reg.reg_write  && src_match(id_ex_reg.dst,  id_src[gi])) ||
                                   (ex_mem_reg.reg_write && src_match(ex_mem_reg.dst, id_src[gi])));
            assign fwd_sel[gi]  = !FWD_EN ? FWD_RF :
                                  (ex_mem_reg.reg_write && src_match(ex_mem_reg.dst, ex_src[gi])) ? FWD_EXMEM :
                                  (mem_wb_reg.reg_write && src_match(mem_wb_reg.dst, ex_src[gi])) ? FWD_MEMWB :
                                  FWD_RF;
        end
    endgenerate

    assign hazard = bus.instr_valid && !bus.flush_id && ((|load_hit) || (|raw_hit));

    always_comb begin
        id_ex_next = '0;
        if (bus.instr_valid && !bus.flush_id && !hazard) begin
            id_ex_next = id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_reg  <= '0;
            ex_mem_reg <= '0;
            mem_wb_reg <= '0;
        end else if (!bus.stall_ext) begin
            id_ex_reg  <= id_ex_next;
            ex_mem_reg <= id_ex_reg;
            mem_wb_reg <= ex_mem_reg;
        end
    end

    assign bus.illegal_id          = id_illegal;
    assign bus.hazard_stall        = hazard;
    assign bus.ex_alu_control      = id_ex_reg.alu_control;
    assign bus.ex_alu_source       = id_ex_reg.alu_source;
    assign bus.ex_alu_source_shift = id_ex_reg.alu_source_shift;
    assign bus.ex_branch           = id_ex_reg.branch;
    assign bus.ex_branch_ne        = id_ex_reg.branch_ne;
    assign bus.fwd_a               = fwd_sel[0];
    assign bus.fwd_b               = fwd_sel[1];
    assign bus.mem_mem_read        = ex_mem_reg.mem_read;
    assign bus.mem_mem_write       = ex_mem_reg.mem_write;
    assign bus.wb_reg_write        = mem_wb_reg.reg_write;
    assign bus.wb_mem_to_reg       = mem_wb_reg.mem_to_reg;
    assign bus.wb_dst              = ADDR_W'(mem_wb_reg.dst);

    // Later stages only expose a subset of the bundle.
    logic unused_stage_bits;
    assign unused_stage_bits = ^{ex_mem_reg, mem_wb_reg};

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: one forwarding instance and one
// non-forwarding instance driven with the same ID-stage stimulus.
module tb_control_pipe;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_pipe_if #(.ADDR_W(5)) bus_a ();
    control_pipe_if #(.ADDR_W(5)) bus_b ();

    control_pipe #(.ADDR_W(5), .FWD_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    control_pipe #(.ADDR_W(5), .FWD_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic valid,
                         input logic flush, input logic stall);
        bus_a.instr_id = instr; bus_a.instr_valid = valid;
        bus_a.flush_id = flush; bus_a.stall_ext   = stall;
        bus_b.instr_id = instr; bus_b.instr_valid = valid;
        bus_b.flush_id = flush; bus_b.stall_ext   = stall;
        #1;
        $display("[TB] t=%0t instr=%08h valid=%0b flush=%0b stall=%0b",
                 $time, instr, valid, flush, stall);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick;
        tick;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] outs_a;
        return 32'({bus_a.hazard_stall, bus_a.ex_alu_control, bus_a.ex_alu_source,
                    bus_a.ex_alu_source_shift, bus_a.ex_branch, bus_a.ex_branch_ne,
                    bus_a.fwd_a, bus_a.fwd_b, bus_a.mem_mem_read, bus_a.mem_mem_write,
                    bus_a.wb_reg_write, bus_a.wb_mem_to_reg, bus_a.wb_dst});
    endfunction

    logic [31:0] add6, lw6, add_r6, addi14, add14, bne12, ori8, xori9, andi10;

    initial begin
        add6   = 32'h002A3020;
        lw6    = 32'h8C460108;
        add_r6 = rtype(5'd6, 5'd1, 5'd7, 5'd0, FN_ADD);
        addi14 = itype(OP_ADDI, 5'd15, 5'd14, 16'd2);
        add14  = rtype(5'd14, 5'd3, 5'd5, 5'd0, FN_ADD);
        bne12  = itype(OP_BNE, 5'd1, 5'd2, 16'd16);
        ori8   = itype(OP_ORI, 5'd0, 5'd8, 16'd1);
        xori9  = itype(OP_XORI, 5'd0, 5'd9, 16'd1);
        andi10 = itype(OP_ANDI, 5'd0, 5'd10, 16'd1);

        // Reset and basic add latency
        do_reset;
        check("reset_outs_a", outs_a(), 32'h0);
        check("reset_hazard_b", 32'(bus_b.hazard_stall), 32'h0);
        drive(add6, 1'b1, 1'b0, 1'b0);
        check("add_legal", 32'(bus_a.illegal_id), 32'h0);
        tick;
        check("add_ex_alu", 32'(bus_a.ex_alu_control), 32'(ALU_ADD));
        check("add_ex_src", 32'(bus_a.ex_alu_source), 32'h0);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick;
        check("add_not_yet_wb", 32'(bus_a.wb_reg_write), 32'h0);
        tick;
        check("add_wb_write", 32'(bus_a.wb_reg_write), 32'h1);
        check("add_wb_dst", 32'(bus_a.wb_dst), 32'd6);
        check("add_wb_m2r", 32'(bus_a.wb_mem_to_reg), 32'h0);

        // Reset beats stall_ext and flush
        drive(add6, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("reset_dominates", outs_a(), 32'h0);

        // Load-use
        do_reset;
        drive(lw6, 1'b1, 1'b0, 1'b0);
        check("lu_no_stall_first", 32'(bus_a.hazard_stall), 32'h0);
        tick;
        check("lw_ex_src", 32'(bus_a.ex_alu_source), 32'h1);
        drive(add_r6, 1'b1, 1'b0, 1'b0);
        check("lu_stall", 32'(bus_a.hazard_stall), 32'h1);
        tick;
        check("lu_bubble_ex", 32'(bus_a.ex_alu_source), 32'h0);
        check("lu_mem_read", 32'(bus_a.mem_mem_read), 32'h1);
        check("lu_stall_once", 32'(bus_a.hazard_stall), 32'h0);
        tick;
        check("lu_fwd_a", 32'(bus_a.fwd_a), 32'(FWD_MEMWB));
        check("lu_fwd_b", 32'(bus_a.fwd_b), 32'(FWD_RF));
        check("lu_wb_m2r", 32'(bus_a.wb_mem_to_reg), 32'h1);
        check("lu_wb_dst", 32'(bus_a.wb_dst), 32'd6);

        // Back-to-back RAW, with and without forwarding
        do_reset;
        drive(addi14, 1'b1, 1'b0, 1'b0);
        check("raw_b_first", 32'(bus_b.hazard_stall), 32'h0);
        tick;
        drive(add14, 1'b1, 1'b0, 1'b0);
        check("raw_a_no_stall", 32'(bus_a.hazard_stall), 32'h0);
        check("raw_b_stall1", 32'(bus_b.hazard_stall), 32'h1);
        tick;
        check("raw_a_fwd_a", 32'(bus_a.fwd_a), 32'(FWD_EXMEM));
        check("raw_a_fwd_b", 32'(bus_a.fwd_b), 32'(FWD_RF));
        check("raw_b_stall2", 32'(bus_b.hazard_stall), 32'h1);
        check("raw_b_bubble", 32'(bus_b.ex_alu_source), 32'h0);
        tick;
        check("raw_b_release", 32'(bus_b.hazard_stall), 32'h0);
        tick;
        check("raw_b_fwd_a", 32'(bus_b.fwd_a), 32'(FWD_RF));
        check("raw_b_wb_idle", 32'(bus_b.wb_reg_write), 32'h0);

        // EX/MEM wins over MEM/WB
        do_reset;
        drive(addi14, 1'b1, 1'b0, 1'b0);
        tick;
        drive(itype(OP_ADDI, 5'd14, 5'd14, 16'd3), 1'b1, 1'b0, 1'b0);
        tick;
        drive(add14, 1'b1, 1'b0, 1'b0);
        tick;
        check("prio_exmem", 32'(bus_a.fwd_a), 32'(FWD_EXMEM));

        // Shifts
        do_reset;
        drive(itype(OP_LW, 5'd2, 5'd4, 16'd8), 1'b1, 1'b0, 1'b0);
        tick;
        drive(32'h00831840, 1'b1, 1'b0, 1'b0);
        check("sll_no_rs_stall", 32'(bus_a.hazard_stall), 32'h0);
        tick;
        check("sll_alu", 32'(bus_a.ex_alu_control), 32'(ALU_SLL));
        check("sll_shift", 32'(bus_a.ex_alu_source_shift), 32'h1);
        check("sll_fwd_a", 32'(bus_a.fwd_a), 32'(FWD_RF));
        drive(rtype(5'd2, 5'd3, 5'd4, 5'd0, FN_SRAV), 1'b1, 1'b0, 1'b0);
        tick;
        check("srav_alu", 32'(bus_a.ex_alu_control), 32'(ALU_SRA));
        check("srav_shift", 32'(bus_a.ex_alu_source_shift), 32'h0);
        drive(rtype(5'd0, 5'd5, 5'd6, 5'd2, FN_SRL), 1'b1, 1'b0, 1'b0);
        tick;
        check("srl_alu", 32'(bus_a.ex_alu_control), 32'(ALU_SRL));
        check("srl_shift", 32'(bus_a.ex_alu_source_shift), 32'h1);

        // Flush
        do_reset;
        drive(bne12, 1'b1, 1'b0, 1'b0);
        tick;
        check("bne_branch", 32'(bus_a.ex_branch), 32'h1);
        check("bne_ne", 32'(bus_a.ex_branch_ne), 32'h1);
        check("bne_alu", 32'(bus_a.ex_alu_control), 32'(ALU_SUB));
        drive(ori8, 1'b1, 1'b1, 1'b0);
        tick;
        check("flush_bubble_br", 32'(bus_a.ex_branch), 32'h0);
        check("flush_bubble_alu", 32'(bus_a.ex_alu_control), 32'h0);
        drive(lw6, 1'b1, 1'b0, 1'b0);
        tick;
        drive(add_r6, 1'b1, 1'b1, 1'b0);
        check("flush_wins", 32'(bus_a.hazard_stall), 32'h0);
        tick;
        check("flush_lw_mem", 32'(bus_a.mem_mem_read), 32'h1);

        // stall_ext holds everything
        do_reset;
        drive(ori8, 1'b1, 1'b0, 1'b0);
        tick;
        drive(xori9, 1'b1, 1'b0, 1'b0);
        tick;
        drive(andi10, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("stall_ex_held", 32'(bus_a.ex_alu_control), 32'(ALU_XOR));
            check("stall_wb_held", 32'(bus_a.wb_reg_write), 32'h0);
        end
        drive(andi10, 1'b1, 1'b0, 1'b0);
        tick;
        check("resume_ex", 32'(bus_a.ex_alu_control), 32'(ALU_AND));
        check("resume_wb8", 32'(bus_a.wb_dst), 32'd8);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick;
        check("resume_wb9", 32'(bus_a.wb_dst), 32'd9);
        tick;
        check("resume_wb10", 32'(bus_a.wb_dst), 32'd10);
        tick;
        check("resume_drained", 32'(bus_a.wb_reg_write), 32'h0);

        // Illegal encodings
        do_reset;
        drive(32'hFC000000, 1'b1, 1'b0, 1'b0);
        check("illegal_op", 32'(bus_a.illegal_id), 32'h1);
        tick;
        drive(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b001000), 1'b1, 1'b0, 1'b0);
        check("illegal_funct", 32'(bus_a.illegal_id), 32'h1);
        tick;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick;
        check("illegal_op_wb", 32'(bus_a.wb_reg_write), 32'h0);
        tick;
        check("illegal_fn_wb", 32'(bus_a.wb_reg_write), 32'h0);

        // Writes to r0 create no dependency
        do_reset;
        drive(rtype(5'd1, 5'd2, 5'd0, 5'd0, FN_ADD), 1'b1, 1'b0, 1'b0);
        tick;
        drive(rtype(5'd0, 5'd0, 5'd5, 5'd0, FN_OR), 1'b1, 1'b0, 1'b0);
        check("r0_a_no_stall", 32'(bus_a.hazard_stall), 32'h0);
        check("r0_b_no_stall", 32'(bus_b.hazard_stall), 32'h0);
        tick;
        check("r0_fwd_a", 32'(bus_a.fwd_a), 32'(FWD_RF));
        check("r0_fwd_b", 32'(bus_a.fwd_b), 32'(FWD_RF));
        check("r0_or_alu", 32'(bus_a.ex_alu_control), 32'(ALU_OR));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
